// File: rtl/amp_pwr_seq.sv
// amp_pwr_seq: N-channel class-D amplifier power sequencer with fault debounce, retry and lockout
module amp_pwr_seq #(
    parameter int NUM_AMP     = 2,
    parameter int STARTUP_CYC = 250000,
    parameter int DEB_CYC     = 16,
    parameter int RETRY_CYC   = 5000000,
    parameter int MAX_RETRY   = 3,
    parameter int GANG        = 1,
    localparam int RW         = $clog2(MAX_RETRY + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_AMP-1:0] flt_n,
    input  logic               q_full,
    input  logic               clr_flt,
    output logic [NUM_AMP-1:0] sht_dwn,
    output logic [NUM_AMP-1:0] fault_latched,
    output logic [RW-1:0]      retry_cnt,
    output logic [1:0]         state
);
    typedef enum logic [1:0] {START, RUN, FAULT_HOLD, LOCKOUT} st_t;
    localparam int TMAX = (STARTUP_CYC > RETRY_CYC) ? STARTUP_CYC : RETRY_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_START = TW'(STARTUP_CYC - 1);
    localparam logic [TW-1:0] T_RUN   = TW'(RETRY_CYC);
    localparam logic [TW-1:0] T_HOLD  = TW'(RETRY_CYC - 1);
    localparam logic [7:0]    DEB     = 8'(DEB_CYC);
    localparam logic [RW-1:0] RMAX    = RW'(MAX_RETRY);

    logic [NUM_AMP-1:0] s1, s2, flt_det, fl_d, sht_d;
    logic [TW-1:0]      tmr, tmr_d;
    logic [RW-1:0]      rty_d;
    logic               any_det, fault_go;
    st_t                st_q, st_d;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= flt_n;
            s2 <= s1;
        end

    for (genvar i = 0; i < NUM_AMP; i++) begin : g_deb
        logic [7:0] cnt;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) cnt <= '0;
            else cnt <= s2[i] ? 8'd0 : (cnt == DEB) ? cnt : cnt + 8'd1;
        assign flt_det[i] = cnt == DEB;
    end

    assign any_det = |flt_det;

    // one shared timer: START settle, RUN clean-run, FAULT_HOLD hold-off
    always_comb begin
        st_d     = st_q;
        tmr_d    = tmr;
        rty_d    = retry_cnt;
        fault_go = 1'b0;
        fl_d     = (clr_flt ? '0 : fault_latched) | flt_det;
        case (st_q)
            START: begin
                tmr_d = (tmr == T_START) ? tmr : tmr + 1'b1;
                if (tmr == T_START && q_full) begin
                    fault_go = any_det;
                    if (!any_det) begin
                        st_d  = RUN;
                        tmr_d = '0;
                    end
                end
            end
            RUN: begin
                tmr_d    = (tmr == T_RUN) ? tmr : tmr + 1'b1;
                rty_d    = (tmr == T_RUN) ? '0 : retry_cnt;
                fault_go = any_det;
            end
            FAULT_HOLD: begin
                tmr_d = any_det ? '0 : tmr + 1'b1;
                if (!any_det && tmr == T_HOLD) begin
                    st_d  = START;
                    tmr_d = '0;
                end
            end
            LOCKOUT:
                if (clr_flt) begin
                    st_d  = START;
                    tmr_d = '0;
                    rty_d = '0;
                end
        endcase
        if (fault_go) begin
            st_d  = (retry_cnt == RMAX) ? LOCKOUT : FAULT_HOLD;
            rty_d = (retry_cnt == RMAX) ? retry_cnt : retry_cnt + 1'b1;
            tmr_d = '0;
        end
        sht_d = (st_d == RUN) ? '0 : (st_d == FAULT_HOLD && GANG == 0) ? fl_d : '1;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st_q          <= START;
            tmr           <= '0;
            retry_cnt     <= '0;
            fault_latched <= '0;
            sht_dwn       <= '1;
        end else begin
            st_q          <= st_d;
            tmr           <= tmr_d;
            retry_cnt     <= rty_d;
            fault_latched <= fl_d;
            sht_dwn       <= sht_d;
        end

    assign state = st_q;
endmodule

// File: tb/tb_amp_pwr_seq.sv
// tb_amp_pwr_seq: scoreboard bench for amp_pwr_seq, one GANG=1 and one GANG=0 instance
module tb_amp_pwr_seq;
    localparam int ST_START = 0, ST_RUN = 1, ST_HOLD = 2, ST_LOCK = 3;
    localparam int S_ST = 0, S_SHT = 1, S_FL = 2, S_RTY = 3;
    localparam int S0_ST = 4, S0_SHT = 5, S0_FL = 6, S0_RTY = 7;

    logic       clk = 1'b0, rst_n = 1'b0, q_full = 1'b0, clr_flt = 1'b0;
    logic [1:0] flt_n = 2'b11, flt0_n = 2'b11;
    logic [1:0] sht, fl, rty, st, sht0, fl0, rty0, st0;
    int         cyc = 0, n_chk = 0, n_pass = 0;
    int         cq[$], sq[$], vq[$];
    string      tq[$];
    int         b, c, d, e, f, g, h, k;

    amp_pwr_seq #(.NUM_AMP(2), .STARTUP_CYC(20), .DEB_CYC(4), .RETRY_CYC(50), .MAX_RETRY(2), .GANG(1)) dut (
        .clk(clk), .rst_n(rst_n), .flt_n(flt_n), .q_full(q_full), .clr_flt(clr_flt),
        .sht_dwn(sht), .fault_latched(fl), .retry_cnt(rty), .state(st));

    amp_pwr_seq #(.NUM_AMP(2), .STARTUP_CYC(20), .DEB_CYC(4), .RETRY_CYC(50), .MAX_RETRY(2), .GANG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flt_n(flt0_n), .q_full(q_full), .clr_flt(clr_flt),
        .sht_dwn(sht0), .fault_latched(fl0), .retry_cnt(rty0), .state(st0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    endtask

    task automatic expect_at(input int at, input int sel, input int v, input string tag);
        cq.push_back(at);
        sq.push_back(sel);
        vq.push_back(v);
        tq.push_back(tag);
    endtask

    task automatic expect_reset(input int at);
        expect_at(at, S_ST, ST_START, "rst_state");
        expect_at(at, S_SHT, 3, "rst_sht");
        expect_at(at, S_FL, 0, "rst_fl");
        expect_at(at, S_RTY, 0, "rst_rty");
        expect_at(at, S0_ST, ST_START, "rst_state0");
        expect_at(at, S0_SHT, 3, "rst_sht0");
        expect_at(at, S0_FL, 0, "rst_fl0");
        expect_at(at, S0_RTY, 0, "rst_rty0");
    endtask

    task automatic wait_cyc(input int at);
        while (cyc < at) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int obs(input int sel);
        case (sel)
            S_ST:    return int'(st);
            S_SHT:   return int'(sht);
            S_FL:    return int'(fl);
            S_RTY:   return int'(rty);
            S0_ST:   return int'(st0);
            S0_SHT:  return int'(sht0);
            S0_FL:   return int'(fl0);
            default: return int'(rty0);
        endcase
    endfunction

    // outputs sampled on the falling edge, away from the registering edge
    always @(negedge clk)
        for (int j = cq.size() - 1; j >= 0; j--)
            if (cq[j] <= cyc) begin
                chk(tq[j], obs(sq[j]), vq[j]);
                cq.delete(j);
                sq.delete(j);
                vq.delete(j);
                tq.delete(j);
            end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        expect_reset(2);
        wait_cyc(3);
        rst_n = 1'b1;
        b = cyc;
        expect_at(b + 20, S_ST, ST_START, "qf0_start20");
        expect_at(b + 60, S_ST, ST_START, "qf0_start60");
        expect_at(b + 60, S_SHT, 3, "qf0_sht60");
        wait_cyc(b + 60);
        q_full = 1'b1;
        expect_at(b + 61, S_ST, ST_RUN, "qf1_run");
        expect_at(b + 61, S_SHT, 0, "qf1_sht");
        wait_cyc(b + 63);
        rst_n = 1'b0;
        wait_cyc(b + 65);
        rst_n = 1'b1;
        b = cyc;
        expect_at(b + 19, S_ST, ST_START, "start19");
        expect_at(b + 19, S_SHT, 3, "sht_start19");
        expect_at(b + 20, S_ST, ST_RUN, "run20");
        expect_at(b + 20, S_SHT, 0, "sht_run20");
        expect_at(b + 20, S0_ST, ST_RUN, "run20_g0");
        expect_at(b + 20, S0_SHT, 0, "sht_run20_g0");
        wait_cyc(b + 22);
        b = cyc;
        flt_n[0] = 1'b0;
        expect_at(b + 8, S_SHT, 0, "short_pulse_sht");
        expect_at(b + 10, S_ST, ST_RUN, "short_pulse_state");
        wait_cyc(b + 3);
        flt_n[0] = 1'b1;
        wait_cyc(b + 12);
        c = cyc;
        flt_n[0] = 1'b0;
        expect_at(c + 6, S_SHT, 0, "deb_sht_before");
        expect_at(c + 6, S_FL, 0, "deb_fl_before");
        expect_at(c + 7, S_SHT, 3, "deb_sht_after");
        expect_at(c + 7, S_ST, ST_HOLD, "deb_state_hold");
        expect_at(c + 7, S_FL, 1, "deb_fl_latched");
        expect_at(c + 7, S_RTY, 1, "deb_rty1");
        expect_at(c + 7, S0_ST, ST_RUN, "deb_g0_unaffected");
        expect_at(c + 56, S_ST, ST_HOLD, "hold_last");
        expect_at(c + 57, S_ST, ST_START, "hold_exit");
        expect_at(c + 57, S_SHT, 3, "hold_exit_sht");
        expect_at(c + 76, S_ST, ST_START, "restart_last");
        expect_at(c + 77, S_ST, ST_RUN, "restart_run");
        expect_at(c + 77, S_SHT, 0, "restart_sht");
        wait_cyc(c + 4);
        flt_n[0] = 1'b1;
        wait_cyc(c + 78);
        d = cyc;
        flt_n[0] = 1'b0;
        expect_at(d + 7, S_ST, ST_HOLD, "long_hold");
        expect_at(d + 7, S_RTY, 2, "long_rty2");
        expect_at(d + 100, S_ST, ST_HOLD, "long_hold100");
        expect_at(d + 100, S_SHT, 3, "long_sht100");
        expect_at(d + 152, S_ST, ST_HOLD, "long_hold_last");
        expect_at(d + 153, S_ST, ST_START, "long_hold_exit");
        expect_at(d + 172, S_ST, ST_START, "long_start_last");
        expect_at(d + 173, S_ST, ST_RUN, "long_run");
        expect_at(d + 173, S_FL, 1, "long_fl_sticky");
        wait_cyc(d + 100);
        flt_n[0] = 1'b1;
        wait_cyc(d + 174);
        e = cyc;
        clr_flt = 1'b1;
        expect_at(e + 1, S_FL, 0, "clr_run_fl");
        expect_at(e + 1, S_ST, ST_RUN, "clr_run_state");
        expect_at(e + 1, S_RTY, 2, "clr_run_rty");
        wait_cyc(e + 1);
        clr_flt = 1'b0;
        f = cyc;
        flt_n[1] = 1'b0;
        expect_at(f + 6, S_SHT, 0, "lock_sht_before");
        expect_at(f + 7, S_ST, ST_LOCK, "lock_enter");
        expect_at(f + 7, S_FL, 2, "lock_fl");
        expect_at(f + 7, S_RTY, 2, "lock_rty");
        expect_at(f + 7, S_SHT, 3, "lock_sht");
        expect_at(f + 100, S_ST, ST_LOCK, "lock_stay");
        wait_cyc(f + 4);
        flt_n[1] = 1'b1;
        wait_cyc(f + 110);
        g = cyc;
        clr_flt = 1'b1;
        expect_at(g + 1, S_ST, ST_START, "unlock_state");
        expect_at(g + 1, S_RTY, 0, "unlock_rty");
        expect_at(g + 1, S_FL, 0, "unlock_fl");
        expect_at(g + 1, S_SHT, 3, "unlock_sht");
        expect_at(g + 20, S_ST, ST_START, "unlock_start_last");
        expect_at(g + 21, S_ST, ST_RUN, "unlock_run");
        wait_cyc(g + 1);
        clr_flt = 1'b0;
        wait_cyc(g + 23);
        h = cyc;
        flt_n[0] = 1'b0;
        flt0_n[1] = 1'b0;
        expect_at(h + 6, S0_SHT, 0, "g0_sht_before");
        expect_at(h + 7, S_FL, 1, "setwins_fl");
        expect_at(h + 7, S_ST, ST_HOLD, "setwins_state");
        expect_at(h + 7, S_SHT, 3, "gang_sht");
        expect_at(h + 7, S0_SHT, 2, "g0_sht_partial");
        expect_at(h + 7, S0_ST, ST_HOLD, "g0_state_hold");
        expect_at(h + 7, S0_FL, 2, "setwins_fl0");
        expect_at(h + 7, S0_RTY, 1, "g0_rty1");
        expect_at(h + 19, S0_SHT, 2, "g0_sht_hold");
        wait_cyc(h + 4);
        flt_n[0] = 1'b1;
        flt0_n[1] = 1'b1;
        wait_cyc(h + 6);
        clr_flt = 1'b1;
        wait_cyc(h + 7);
        clr_flt = 1'b0;
        wait_cyc(h + 20);
        expect_reset(h + 20);
        #2;
        rst_n = 1'b0;
        wait_cyc(h + 23);
        rst_n = 1'b1;
        k = cyc;
        expect_at(k + 20, S_ST, ST_RUN, "post_rst_run");
        expect_at(k + 20, S0_ST, ST_RUN, "post_rst_run0");
        wait_cyc(k + 22);
        k = cyc;
        flt0_n[1] = 1'b0;
        expect_at(k + 7, S0_ST, ST_HOLD, "g0b_hold");
        expect_at(k + 7, S0_RTY, 1, "g0b_rty1");
        expect_at(k + 7, S0_SHT, 2, "g0b_sht");
        expect_at(k + 57, S0_ST, ST_START, "g0b_start");
        expect_at(k + 77, S0_ST, ST_RUN, "g0b_run");
        expect_at(k + 100, S0_RTY, 1, "g0b_rty_kept");
        expect_at(k + 140, S0_RTY, 0, "g0b_rty_cleared");
        expect_at(k + 140, S_ST, ST_RUN, "g1_still_run");
        wait_cyc(k + 4);
        flt0_n[1] = 1'b1;
        wait_cyc(k + 145);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
